wam_ctl: RTL and testbench
==========================

WAM_CTL -- requirements
Module: wam_ctl

Interface
REQ-001 Parameter TICK_CNT, default 100_000_000: clk cycles per one-second game tick.
REQ-002 Parameter ROUND_SEC, default 60: play-phase length in seconds, legal range 1..99.
REQ-003 Parameter CNTDN_SEC, default 3: pre-game countdown length in seconds, legal range 1..9.
REQ-004 Parameter DB_CYC, default 65536: cycles a button must be stable before it is accepted.
REQ-005 clk  in  1  system clock; single clock domain.
REQ-006 clr  in  1  reset, asynchronous, active-high.
REQ-007 sta  in  1  raw start/abort button, asynchronous.
REQ-008 pse  in  1  raw pause/resume button, asynchronous.
REQ-009 state  out  3  game state code: IDLE=0, CNTDN=1, PLAY=2, PAUSE=3, OVER=4.
REQ-010 sec_left  out  7  seconds remaining in the current phase.
REQ-011 gen_en  out  1  mole generator enable; high only in PLAY.
REQ-012 scr_en  out  1  score/hit accept enable; high only in PLAY.
REQ-013 new_game  out  1  one-cycle pulse; generator and score counter clear on it.
REQ-014 sec_tick  out  1  one-cycle pulse at each game-second boundary.

Function
REQ-015 Each button SHALL pass a 2-FF synchronizer, a DB_CYC stability filter and a rising-edge detector, yielding a one-cycle pulse (sta_p, pse_p).
REQ-016 Press-to-pulse latency SHALL be 2 + DB_CYC + 1 cycles; a held button SHALL produce exactly one pulse.
REQ-017 The tick counter SHALL count 0..TICK_CNT-1 in CNTDN and PLAY, hold in PAUSE, and be zero in IDLE and OVER; sec_tick SHALL assert in the cycle the counter wraps.
REQ-018 IDLE: on sta_p go to CNTDN, load sec_left=CNTDN_SEC, clear tick counter, pulse new_game; pse_p ignored.
REQ-019 CNTDN: on sec_tick decrement sec_left; on sec_tick with sec_left==1 go to PLAY, load ROUND_SEC; pse_p ignored; sta_p aborts to IDLE.
REQ-020 PLAY: on sec_tick decrement sec_left; on sec_tick with sec_left==1 go to OVER with sec_left=0; pse_p goes to PAUSE; sta_p ignored.
REQ-021 PAUSE: pse_p returns to PLAY with tick counter and sec_left unchanged; sta_p aborts to IDLE with sec_left=0.
REQ-022 OVER: sta_p goes to CNTDN as in REQ-018 including new_game pulse; pse_p ignored.
REQ-023 Simultaneous sec_tick and pse_p in PLAY: decrement applies first; if it ends the round OVER wins, else PAUSE.
REQ-024 Simultaneous sta_p and pse_p: sta_p takes priority in every state.
REQ-025 sec_left SHALL never wrap below 0; state codes 5..7 SHALL recover to IDLE next cycle.
REQ-026 All outputs SHALL be registered; gen_en/scr_en/state change in the same cycle.

Reset
REQ-027 clr SHALL force state=IDLE, sec_left=0, gen_en=0, scr_en=0, new_game=0, sec_tick=0, tick counter=0, synchronizer/debounce/edge registers=0, immediately and independent of clk.
REQ-028 clr asserted mid-PLAY SHALL not produce a new_game pulse on release.

Structure
REQ-029 State codes and ROUND_SEC/CNTDN_SEC defaults SHALL live in shared package wam_pkg, also used by the display block.
REQ-030 Button conditioning SHALL be sub-module wam_btn (sync, debounce, edge), instantiated twice.

Verification (TICK_CNT=10, ROUND_SEC=3, CNTDN_SEC=2, DB_CYC=4)
REQ-031 sta held 20 cycles from IDLE -> one new_game pulse 7 cycles after press, state=1, sec_left=2; PLAY after 20 more cycles with sec_left=3.
REQ-032 Full round -> sec_left 3,2,1 in PLAY, state=4 and gen_en=0 30 cycles after PLAY entry; sec_left=0.
REQ-033 pse pulse in PLAY at tick count 4 -> PAUSE, counter frozen at 4 for 50 cycles; second pse -> PLAY, next sec_tick 6 cycles later.
REQ-034 pse_p coincident with final sec_tick -> state=OVER, not PAUSE.
REQ-035 sta 2-cycle glitch (< DB_CYC) -> no transition; clr asserted mid-PLAY -> all outputs zero same cycle, no new_game.

Source files
------------

// File: rtl/wam_pkg.sv
// wam_pkg: definitions shared by the game controller and the score/display blocks.
//   state_t       game state codes, driven on wam_ctl.state
//   *_SEC_DEF     default phase lengths in seconds
//   sec_dec()     seconds decrement that saturates at zero
package wam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CNTDN = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int ROUND_SEC_DEF = 60;
  localparam int CNTDN_SEC_DEF = 3;
  localparam int SEC_W         = 7;

  function automatic logic [SEC_W-1:0] sec_dec(input logic [SEC_W-1:0] s);
    return (s == '0) ? '0 : s - 1'b1;
  endfunction

endpackage

// File: rtl/wam_btn.sv
// wam_btn: conditions one raw push-button into a single-cycle press pulse.
//   clk    system clock
//   rst    asynchronous active-high reset
//   btn    raw asynchronous button level
//   pulse  one-cycle pulse on each accepted press (rising edge of the filtered level)
module wam_btn #(
  parameter int DB_CYC = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DB_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYC - 1);

  logic          s1, s2;
  logic          db, db_q;
  logic [CW-1:0] cnt;

  // The filtered level only follows the synchronized input after it has
  // differed from the current filtered value for DB_CYC consecutive cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      db_q <= db;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign pulse = db & ~db_q;

endmodule

// File: rtl/wam_ctl.sv
// wam_ctl: whack-a-mole game sequencer (countdown, timed round, pause, game over).
//   clk       system clock
//   clr       asynchronous active-high reset
//   sta, pse  raw start/abort and pause/resume buttons
//   state     game state code (wam_pkg::state_t)
//   sec_left  seconds remaining in the current phase
//   gen_en    mole generator enable (PLAY only)
//   scr_en    score accept enable (PLAY only)
//   new_game  one-cycle pulse when a game is started
//   sec_tick  one-cycle pulse at each game-second boundary
//
// state | meaning
// IDLE  | waiting for start, timers cleared
// CNTDN | pre-game countdown, sta aborts
// PLAY  | round running, moles and scoring enabled
// PAUSE | round frozen (tick counter and seconds held)
// OVER  | round finished, sta starts a new game
module wam_ctl
  import wam_pkg::*;
#(
  parameter int TICK_CNT  = 100_000_000,
  parameter int ROUND_SEC = ROUND_SEC_DEF,
  parameter int CNTDN_SEC = CNTDN_SEC_DEF,
  parameter int DB_CYC    = 65536
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sta,
  input  logic             pse,
  output logic [2:0]       state,
  output logic [SEC_W-1:0] sec_left,
  output logic             gen_en,
  output logic             scr_en,
  output logic             new_game,
  output logic             sec_tick
);

  localparam int TW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam logic [TW-1:0]    TICK_MAX = TW'(TICK_CNT - 1);
  localparam logic [SEC_W-1:0] ROUND_LD = SEC_W'(ROUND_SEC);
  localparam logic [SEC_W-1:0] CNTDN_LD = SEC_W'(CNTDN_SEC);

  logic sta_p, pse_p;

  wam_btn #(.DB_CYC(DB_CYC)) u_btn_sta (.clk(clk), .rst(clr), .btn(sta), .pulse(sta_p));
  wam_btn #(.DB_CYC(DB_CYC)) u_btn_pse (.clk(clk), .rst(clr), .btn(pse), .pulse(pse_p));

  state_t           st_q, st_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic             run, wrap;
  logic             gen_en_d, new_game_d, sec_tick_d;

  assign run  = (st_q == ST_CNTDN) || (st_q == ST_PLAY);
  assign wrap = run && (tick_q == TICK_MAX);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st_q     <= ST_IDLE;
      sec_q    <= '0;
      tick_q   <= '0;
      gen_en   <= 1'b0;
      scr_en   <= 1'b0;
      new_game <= 1'b0;
      sec_tick <= 1'b0;
    end else begin
      st_q     <= st_d;
      sec_q    <= sec_d;
      tick_q   <= tick_d;
      gen_en   <= gen_en_d;
      scr_en   <= gen_en_d;
      new_game <= new_game_d;
      sec_tick <= sec_tick_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    sec_d  = sec_q;
    tick_d = run ? (wrap ? '0 : tick_q + 1'b1) : tick_q;
    case (st_q)
      ST_IDLE, ST_OVER: begin
        tick_d = '0;
        if (sta_p) begin
          st_d  = ST_CNTDN;
          sec_d = CNTDN_LD;
        end
      end
      ST_CNTDN: begin
        if (sta_p) begin
          st_d   = ST_IDLE;
          sec_d  = '0;
          tick_d = '0;
        end else if (wrap) begin
          if (sec_q <= 1) begin
            st_d  = ST_PLAY;
            sec_d = ROUND_LD;
          end else begin
            sec_d = sec_dec(sec_q);
          end
        end
      end
      ST_PLAY: begin
        // The second boundary is applied before a pause; ending the round wins.
        if (wrap && sec_q <= 1) begin
          st_d   = ST_OVER;
          sec_d  = '0;
          tick_d = '0;
        end else begin
          if (wrap) sec_d = sec_dec(sec_q);
          if (pse_p) st_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (sta_p) begin
          st_d   = ST_IDLE;
          sec_d  = '0;
          tick_d = '0;
        end else if (pse_p) begin
          st_d = ST_PLAY;
        end
      end
      default: begin
        st_d   = ST_IDLE;
        sec_d  = '0;
        tick_d = '0;
      end
    endcase
  end

  always_comb begin
    gen_en_d   = (st_d == ST_PLAY);
    new_game_d = sta_p && ((st_q == ST_IDLE) || (st_q == ST_OVER));
    sec_tick_d = wrap;
  end

  assign state    = st_q;
  assign sec_left = sec_q;

endmodule

// File: tb/tb_wam_ctl.sv
module tb_wam_ctl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       sta = 1'b0;
  logic       pse = 1'b0;
  logic [2:0] state;
  logic [6:0] sec_left;
  logic       gen_en, scr_en, new_game, sec_tick;

  int checks = 0;
  int errors = 0;
  int ng_cnt = 0;

  wam_ctl #(.TICK_CNT(10), .ROUND_SEC(3), .CNTDN_SEC(2), .DB_CYC(4)) dut (
    .clk(clk), .clr(clr), .sta(sta), .pse(pse),
    .state(state), .sec_left(sec_left), .gen_en(gen_en), .scr_en(scr_en),
    .new_game(new_game), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (new_game === 1'b1) ng_cnt++;

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presses sta from IDLE/OVER and returns just after the PLAY entry edge.
  task automatic start_game();
    bit got;
    sta = 1'b1;
    step(8);
    sta = 1'b0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      if (state === 3'd2) got = 1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL start_game_timeout: state %0d required 2", state); end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({state, sec_left, gen_en, scr_en, new_game, sec_tick} !== 14'd0) begin
      errors++; $display("FAIL reset_outputs: state %0d sec %0d gen %b scr %b ng %b tick %b required all 0",
                         state, sec_left, gen_en, scr_en, new_game, sec_tick);
    end
    #4 clr = 1'b0;
    step();
  endtask

  task automatic test_start_countdown();
    int ng0 = ng_cnt;
    sta = 1'b1;
    for (int i = 1; i <= 27; i++) begin
      step();
      if (i == 20) sta = 1'b0;
      if (i == 6) begin
        checks++;
        if (state !== 3'd0 || new_game !== 1'b0) begin
          errors++; $display("FAIL early_start: state %0d ng %b required 0 0", state, new_game);
        end
      end
      if (i == 7) begin
        checks++;
        if (new_game !== 1'b1 || state !== 3'd1 || sec_left !== 7'd2) begin
          errors++; $display("FAIL start_latency: ng %b state %0d sec %0d required 1 1 2", new_game, state, sec_left);
        end
      end
      if (i == 26) begin
        checks++;
        if (state !== 3'd1 || sec_left !== 7'd1) begin
          errors++; $display("FAIL cntdn_last: state %0d sec %0d required 1 1", state, sec_left);
        end
      end
      if (i == 27) begin
        checks++;
        if (state !== 3'd2 || sec_left !== 7'd3) begin
          errors++; $display("FAIL play_entry: state %0d sec %0d required 2 3", state, sec_left);
        end
      end
    end
    checks++;
    if (ng_cnt - ng0 !== 1) begin errors++; $display("FAIL single_new_game: got %0d pulses required 1", ng_cnt - ng0); end
  endtask

  task automatic test_full_round();
    int ticks = 0;
    for (int j = 1; j <= 30; j++) begin
      step();
      if (sec_tick === 1'b1) ticks++;
      if (j == 1) begin
        checks++;
        if (sec_left !== 7'd3 || gen_en !== 1'b1 || scr_en !== 1'b1) begin
          errors++; $display("FAIL play_enables: sec %0d gen %b scr %b required 3 1 1", sec_left, gen_en, scr_en);
        end
      end
      if (j == 11 || j == 21) begin
        checks++;
        if (sec_left !== ((j == 11) ? 7'd2 : 7'd1)) begin
          errors++; $display("FAIL play_sec_%0d: got %0d required %0d", j, sec_left, (j == 11) ? 2 : 1);
        end
      end
      if (j == 29) begin
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL play_end_early: state %0d required 2", state); end
      end
    end
    checks++;
    if (state !== 3'd4 || gen_en !== 1'b0 || scr_en !== 1'b0 || sec_left !== 7'd0 || ticks != 3) begin
      errors++; $display("FAIL round_over: state %0d gen %b scr %b sec %0d ticks %0d required 4 0 0 0 3",
                         state, gen_en, scr_en, sec_left, ticks);
    end
  endtask

  task automatic test_restart_and_abort();
    sta = 1'b1;
    step(7);
    checks++;
    if (state !== 3'd1 || new_game !== 1'b1 || sec_left !== 7'd2) begin
      errors++; $display("FAIL over_restart: state %0d ng %b sec %0d required 1 1 2", state, new_game, sec_left);
    end
    step();
    sta = 1'b0;
    step(9);
    checks++;
    if (state !== 3'd1 || sec_left !== 7'd1) begin
      errors++; $display("FAIL cntdn_dec: state %0d sec %0d required 1 1", state, sec_left);
    end
    sta = 1'b1;
    step(7);
    checks++;
    if (state !== 3'd0 || sec_left !== 7'd0 || new_game !== 1'b0) begin
      errors++; $display("FAIL cntdn_abort: state %0d sec %0d ng %b required 0 0 0", state, sec_left, new_game);
    end
    sta = 1'b0;
    step(12);
  endtask

  task automatic test_glitch();
    int ng0 = ng_cnt;
    int bad = 0;
    sta = 1'b1;
    step(2);
    sta = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (state !== 3'd0) bad++;
    end
    checks++;
    if (bad != 0 || ng_cnt != ng0) begin
      errors++; $display("FAIL glitch_ignored: bad cycles %0d new_game pulses %0d required 0 0", bad, ng_cnt - ng0);
    end
  endtask

  task automatic test_pause_resume();
    int bad = 0;
    int lat = -1;
    start_game();
    step(7);
    pse = 1'b1;
    step(7);
    checks++;
    if (state !== 3'd3 || sec_left !== 7'd2 || gen_en !== 1'b0 || scr_en !== 1'b0) begin
      errors++; $display("FAIL pause_entry: state %0d sec %0d gen %b scr %b required 3 2 0 0", state, sec_left, gen_en, scr_en);
    end
    step(3);
    pse = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (state !== 3'd3 || sec_tick !== 1'b0 || sec_left !== 7'd2) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL pause_hold: %0d cycles moved, required 0", bad); end
    pse = 1'b1;
    step(7);
    checks++;
    if (state !== 3'd2 || gen_en !== 1'b1) begin
      errors++; $display("FAIL resume: state %0d gen %b required 2 1", state, gen_en);
    end
    pse = 1'b0;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      step();
      if (sec_tick === 1'b1) lat = k;
    end
    checks++;
    if (lat != 6 || sec_left !== 7'd1) begin
      errors++; $display("FAIL resume_tick: latency %0d sec %0d required 6 1", lat, sec_left);
    end
  endtask

  // Continues the game left by test_pause_resume: counter 0, sec_left 1.
  task automatic test_coincident_final();
    step(3);
    pse = 1'b1;
    step(7);
    checks++;
    if (state !== 3'd4 || sec_left !== 7'd0 || gen_en !== 1'b0 || sec_tick !== 1'b1) begin
      errors++; $display("FAIL final_tick_vs_pause: state %0d sec %0d gen %b tick %b required 4 0 0 1",
                         state, sec_left, gen_en, sec_tick);
    end
    pse = 1'b0;
    step(10);
  endtask

  task automatic test_back_to_back();
    start_game();
    step(3);
    pse = 1'b1;
    step(7);
    checks++;
    if (state !== 3'd3 || sec_left !== 7'd2 || sec_tick !== 1'b1) begin
      errors++; $display("FAIL tick_then_pause: state %0d sec %0d tick %b required 3 2 1", state, sec_left, sec_tick);
    end
    pse = 1'b0;
    step(10);
    sta = 1'b1;
    pse = 1'b1;
    step(7);
    checks++;
    if (state !== 3'd0 || sec_left !== 7'd0 || new_game !== 1'b0) begin
      errors++; $display("FAIL sta_priority: state %0d sec %0d ng %b required 0 0 0", state, sec_left, new_game);
    end
    sta = 1'b0;
    pse = 1'b0;
    step(12);
  endtask

  task automatic test_clr_mid_play();
    int ng0;
    start_game();
    step(5);
    #2 clr = 1'b1;
    #1;
    checks++;
    if ({state, sec_left, gen_en, scr_en, new_game, sec_tick} !== 14'd0) begin
      errors++; $display("FAIL clr_async: state %0d sec %0d gen %b scr %b ng %b tick %b required all 0",
                         state, sec_left, gen_en, scr_en, new_game, sec_tick);
    end
    step(3);
    #2 clr = 1'b0;
    ng0 = ng_cnt;
    step(20);
    checks++;
    if (ng_cnt != ng0 || state !== 3'd0 || sec_left !== 7'd0) begin
      errors++; $display("FAIL clr_release: ng pulses %0d state %0d sec %0d required 0 0 0", ng_cnt - ng0, state, sec_left);
    end
  endtask

  initial begin
    test_reset();
    test_start_countdown();
    test_full_round();
    test_restart_and_abort();
    test_glitch();
    test_pause_resume();
    test_coincident_final();
    test_back_to_back();
    test_clr_mid_play();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
